// File: rtl/and_arb_pkg.sv
// Shared types and width helpers for the round-robin AND arbiter.
package and_arb_pkg;

    // Controller states: waiting for a request, or holding a result for the consumer.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/and_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module and_rr_pick
    import and_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = idw_of(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] w
);

    // Scan from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        int idx;
        found = 1'b0;
        w     = '0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                found = 1'b1;
                w     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/and_arb_ctrl.sv
// Round-robin arbiter sharing one registered bitwise-AND among N requesters.
module and_arb_ctrl
    import and_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int IDW = idw_of(N)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N-1:0]     REQ,
    input  logic [N*W-1:0]   A,
    input  logic [N*W-1:0]   B,
    output logic [N-1:0]     GNT,
    output logic [W-1:0]     R,
    output logic [IDW-1:0]   R_ID,
    output logic             R_VALID,
    input  logic             R_READY,
    output logic             BUSY
);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [W-1:0]   r_q, r_d;
    logic [IDW-1:0] r_id_q, r_id_d;
    logic           r_valid_q, r_valid_d;

    logic           pick_found;
    logic [IDW-1:0] pick_w;
    logic [W-1:0]   a_w, b_w;

    and_rr_pick #(.N(N)) u_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .found (pick_found),
        .w     (pick_w)
    );

    // Only the winner's operands reach the AND; they are sampled once, at arbitration.
    assign a_w = A[int'(pick_w) * W +: W];
    assign b_w = B[int'(pick_w) * W +: W];

    // Next-state logic: grant and capture in IDLE, wait for the handshake in RESP.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        r_d       = r_q;
        r_id_d    = r_id_q;
        r_valid_d = r_valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d       = RESP;
                    r_d           = a_w & b_w;
                    r_id_d        = pick_w;
                    gnt_d[pick_w] = 1'b1;
                    r_valid_d     = 1'b1;
                    ptr_d         = (pick_w == IDW'(N - 1)) ? '0 : pick_w + 1'b1;
                end
            end
            RESP: begin
                // Requests are ignored here; the forced IDLE cycle lets the winner drop REQ.
                if (r_valid_q && R_READY) begin
                    r_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything, including the result.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            r_q       <= '0;
            r_id_q    <= '0;
            r_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            r_q       <= r_d;
            r_id_q    <= r_id_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign GNT     = gnt_q;
    assign R       = r_q;
    assign R_ID    = r_id_q;
    assign R_VALID = r_valid_q;
    assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_and_arb_ctrl.sv
// Directed self-checking bench for and_arb_ctrl (N=4, W=8).
module tb_and_arb_ctrl;

    localparam int N = 4;
    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] A, B;
    logic [N-1:0]   GNT;
    logic [W-1:0]   R;
    logic [1:0]     R_ID;
    logic           R_VALID;
    logic           R_READY;
    logic           BUSY;

    int n_assert = 0;
    int n_fail   = 0;

    and_arb_ctrl #(.N(N), .W(W)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .A       (A),
        .B       (B),
        .GNT     (GNT),
        .R       (R),
        .R_ID    (R_ID),
        .R_VALID (R_VALID),
        .R_READY (R_READY),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the full output set in one call.
    task automatic chk_all(input string tag, input logic [3:0] g, input logic [7:0] r,
                           input logic [1:0] id, input logic v, input logic bsy);
        chk({tag, ".gnt"},   32'(GNT),     32'(g));
        chk({tag, ".r"},     32'(R),       32'(r));
        chk({tag, ".r_id"},  32'(R_ID),    32'(id));
        chk({tag, ".valid"}, 32'(R_VALID), 32'(v));
        chk({tag, ".busy"},  32'(BUSY),    32'(bsy));
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        A[i*W +: W] = a;
        B[i*W +: W] = b;
    endtask

    initial begin
        // Operands: R0=11, R1=30, R2=0A, R3=03
        A = '0;
        B = '0;
        set_op(0, 8'hFF, 8'h11);
        set_op(1, 8'hF0, 8'h3C);
        set_op(2, 8'hAA, 8'h0F);
        set_op(3, 8'h0F, 8'hF3);
        RST_N   = 1'b0;
        REQ     = 4'b1111;
        R_READY = 1'b1;

        // Reset held for two edges with all requests high
        step();
        chk_all("rst1", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
        step();
        chk_all("rst2", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);

        // Single request from requester 1
        RST_N = 1'b1;
        REQ   = 4'b0010;
        step();
        chk_all("single", 4'b0010, 8'h30, 2'd1, 1'b1, 1'b1);
        REQ = 4'b0000;
        step();
        chk_all("single_done", 4'b0000, 8'h30, 2'd1, 1'b0, 1'b0);

        // Pointer back to 0 for the rotation run
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;

        // Rotation and wrap: grants 0,1,2,3,0 at two-cycle spacing
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] exp_r;
            int idx;
            idx   = k % 4;
            exp_r = A[idx*W +: W] & B[idx*W +: W];
            step();
            chk_all($sformatf("rot%0d", k), 4'(1 << idx), exp_r, 2'(idx), 1'b1, 1'b1);
            step();
            chk_all($sformatf("rot%0d_idle", k), 4'b0000, exp_r, 2'(idx), 1'b0, 1'b0);
        end

        // Backpressure: grant to requester 2, then stall for five cycles
        REQ     = 4'b0100;
        R_READY = 1'b0;
        step();
        chk_all("bp_gnt", 4'b0100, 8'h0A, 2'd2, 1'b1, 1'b1);
        REQ = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all($sformatf("bp_hold%0d", k), 4'b0000, 8'h0A, 2'd2, 1'b1, 1'b1);
        end
        R_READY = 1'b1;
        step();
        chk_all("bp_release", 4'b0000, 8'h0A, 2'd2, 1'b0, 1'b0);
        step();
        chk_all("bp_next", 4'b1000, 8'h03, 2'd3, 1'b1, 1'b1);
        REQ = 4'b0000;
        step();
        chk_all("bp_next_idle", 4'b0000, 8'h03, 2'd3, 1'b0, 1'b0);

        // Grant to requester 1 moves the pointer to 2, then reset mid-RESP
        REQ     = 4'b0010;
        R_READY = 1'b0;
        step();
        chk_all("pre_rst", 4'b0010, 8'h30, 2'd1, 1'b1, 1'b1);
        RST_N = 1'b0;
        REQ   = 4'b1111;
        step();
        chk_all("mid_rst", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
        RST_N   = 1'b1;
        R_READY = 1'b1;
        step();
        chk_all("post_rst", 4'b0001, 8'h11, 2'd0, 1'b1, 1'b1);

        // Operand change after grant does not disturb the captured result
        REQ     = 4'b0000;
        R_READY = 1'b0;
        set_op(0, 8'h00, 8'h00);
        step();
        chk_all("opchg_hold", 4'b0000, 8'h11, 2'd0, 1'b1, 1'b1);
        R_READY = 1'b1;
        step();
        chk_all("opchg_done", 4'b0000, 8'h11, 2'd0, 1'b0, 1'b0);

        // R_READY with nothing valid and no requests changes nothing
        step();
        chk_all("idle_ready", 4'b0000, 8'h11, 2'd0, 1'b0, 1'b0);

        // New operands are picked up on the next grant (pointer is 1, only req 0 set)
        REQ = 4'b0001;
        set_op(0, 8'h5A, 8'h3F);
        step();
        chk_all("new_op", 4'b0001, 8'h1A, 2'd0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/and_arb_ctrl.md
# and_arb_ctrl

Round-robin arbiter and sequencer that shares one registered bitwise-AND unit among N requesters. Each requester raises a request with its operand pair. The controller picks a winner, registers A&B, and returns the result with the winner's ID over a valid/ready response port. It is the sharing and scheduling front-end for the team's registered AND datapath.

## Interface
- N, default 4: number of requesters, ≥2.
- W, default 8: operand/result width, ≥1.
- IDW, default $clog2(N): ID width (derived, not overridden).
- CLK, in, 1: single clock; all state updates on its rising edge.
- RST_N, in, 1: reset, synchronous, active-low.
- REQ, in, N: per-requester request; bit i held with operands until GNT[i] is seen.
- A, in, N*W: operand A, requester i in bits [i*W +: W].
- B, in, N*W: operand B, same packing.
- GNT, out, N: one-hot grant, high exactly one cycle per accepted request.
- R, out, W: registered result A_w & B_w.
- R_ID, out, IDW: index of the requester that owns R.
- R_VALID, out, 1: R/R_ID valid.
- R_READY, in, 1: consumer accepts R when R_VALID&R_READY at an edge.
- BUSY, out, 1: high when state≠IDLE.

## Operation
- States: IDLE, RESP.
- Reset (RST_N low at an edge) sets state=IDLE, PTR=0, GNT=0, R=0, R_ID=0, R_VALID=0, BUSY=0. Reset overrides every other event.
- IDLE, REQ==0: hold.
- IDLE, REQ≠0: winner w is the first set bit of REQ searching from PTR upward, wrapping at N-1→0. At the edge:
  - state←RESP
  - R←A[w]&B[w]
  - R_ID←w
  - GNT←onehot(w)
  - R_VALID←1
  - PTR←(w+1) mod N
- RESP:
  - GNT←0 at the next edge, so it is a one-cycle pulse.
  - REQ is ignored.
  - R and R_ID stay stable while R_VALID=1.
- RESP, R_VALID&R_READY at an edge: R_VALID←0, state←IDLE. R and R_ID keep their last values.
- Requester rule: drop REQ[i], or present a new operand pair, in the cycle after GNT[i]. The mandatory IDLE cycle guarantees a stale REQ is never re-granted.
- Operand sampling: only the winner's A/B are sampled, in the arbitration cycle. Changes to operands after GNT have no effect.

## Timing
- Request to result: REQ seen in IDLE at cycle t. GNT, R_VALID and R are visible in cycle t+1, i.e. one-cycle latency.
- Minimum spacing between grants is 2 cycles (RESP + IDLE). Peak throughput is one result per 2 cycles.
- Backpressure: R_VALID stays high indefinitely while R_READY=0. No grants are issued during this time.
- R_READY asserted while R_VALID=0 has no effect.
- Reset asserted mid-RESP: the outstanding result is discarded and R_VALID=0 after that edge. The first grant after reset begins the search from requester 0.
- PTR wrap: a grant to N-1 sets PTR=0.
- Fairness: with all REQ continuously high, each requester is granted once per N grants.

## Structure
- Package and_arb_pkg holds:
  - the state enum {IDLE, RESP}
  - localparam helpers for IDW
- Sub-module and_rr_pick: combinational round-robin picker.
  - Inputs: REQ[N], PTR[IDW].
  - Outputs: found, w[IDW].
  - Instantiated once.
- Top level holds the FSM, PTR, and the output registers R, R_ID, R_VALID, GNT.
- The AND is computed inline on the muxed winner operands.

## Test plan
- Reset: hold RST_N=0 for 2 edges with REQ=4'b1111. Required: GNT=0, R=0, R_ID=0, R_VALID=0, BUSY=0 throughout.
- Single request: REQ=4'b0010, A1=8'hF0, B1=8'h3C, R_READY=1. Next cycle: GNT=4'b0010, R=8'h30, R_ID=1, R_VALID=1. The cycle after: R_VALID=0, BUSY=0.
- Rotation and wrap: REQ=4'b1111 held, each requester re-requesting after its grant, R_READY=1. Required grant order 0,1,2,3,0 at 2-cycle spacing, with R_ID matching each grant.
- Backpressure: after a grant to requester 2 (A2=8'hAA, B2=8'h0F), hold R_READY=0 for 5 cycles with REQ=4'b1011. Required: R=8'h0A, R_ID=2, R_VALID=1 stable and no GNT. After R_READY=1, IDLE for one cycle, then a grant to requester 3.
- Reset mid-RESP: assert RST_N=0 during R_VALID=1. Next edge: R_VALID=0, R=0. With REQ=4'b1111 after release, the first GNT is 4'b0001.
- Operand change after grant: the winner changes A/B in the cycle after GNT. Required: R still equals the value sampled at arbitration.
